// File: rtl/uart_frame_tx.sv
// uart_frame_tx: packs a NUM_BYTES payload into SYNC + data (LSB byte first) + XOR
// checksum and feeds it into a UART TX FIFO write port, honouring tx_full.
// A frame is sent on request, on payload change, or as a periodic keep-alive.
module uart_frame_tx #(
  parameter int unsigned              NUM_BYTES      = 3,
  parameter logic [7:0]               SYNC_BYTE      = 8'hA5,
  parameter logic [NUM_BYTES*8-1:0]   INIT_DATA      = 24'h140846,
  parameter bit                       SEND_ON_CHANGE = 1'b1,
  parameter int unsigned              RESEND_CYCLES  = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BYTES*8-1:0] data_in,
  input  logic                   send_req,
  input  logic                   tx_full,
  output logic [7:0]             w_data,
  output logic                   wr_uart,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);
  localparam int unsigned TW = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = (RESEND_CYCLES == 0) ? '0 : TW'(RESEND_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_SYNC,
    SEND_DATA,
    SEND_CSUM
  } state_t;

  state_t                 r_state;
  logic                   r_pending;
  logic [NUM_BYTES*8-1:0] r_snapshot;
  logic [NUM_BYTES*8-1:0] r_last_sent;
  logic [7:0]             r_csum;
  logic [IW-1:0]          r_idx;
  logic [TW-1:0]          r_timer;

  logic [7:0]             w_byte;
  logic                   w_changed;
  logic                   w_timer_hit;
  logic                   w_trigger;

  // Select the snapshot byte addressed by r_idx (byte 0 = least significant).
  always_comb begin
    w_byte = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (r_idx == IW'(i)) w_byte = r_snapshot[i*8 +: 8];
    end
  end

  // Frame start conditions evaluated while idle; any combination yields one frame.
  always_comb begin
    w_changed   = SEND_ON_CHANGE && (data_in != r_last_sent);
    w_timer_hit = (RESEND_CYCLES != 0) && (r_timer == TMAX);
    w_trigger   = send_req || r_pending || w_changed || w_timer_hit;
  end

  // Frame sequencer with registered FIFO write port, status flags and keep-alive timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_snapshot  <= INIT_DATA;
      r_last_sent <= INIT_DATA;
      r_csum      <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      w_data      <= '0;
      wr_uart     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      wr_uart    <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_snapshot  <= data_in;
            r_last_sent <= data_in;
            r_csum      <= '0;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            r_timer     <= '0;
            busy        <= 1'b1;
            r_state     <= SEND_SYNC;
          end else if ((RESEND_CYCLES != 0) && (r_timer != TMAX)) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        SEND_SYNC: begin
          if (send_req) r_pending <= 1'b1;
          if (!tx_full) begin
            wr_uart <= 1'b1;
            w_data  <= SYNC_BYTE;
            r_state <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (send_req) r_pending <= 1'b1;
          if (!tx_full) begin
            wr_uart <= 1'b1;
            w_data  <= w_byte;
            r_csum  <= r_csum ^ w_byte;
            if (r_idx == LAST_IDX) r_state <= SEND_CSUM;
            else                   r_idx   <= r_idx + 1'b1;
          end
        end
        SEND_CSUM: begin
          if (send_req) r_pending <= 1'b1;
          if (!tx_full) begin
            wr_uart    <= 1'b1;
            w_data     <= r_csum;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx: directed frame scenarios plus randomized traffic,
// checked cycle by cycle against a queue-based frame model for two instances
// (keep-alive disabled, and keep-alive every 16 idle cycles).
module tb_uart_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data_in;
  logic        send_req;
  logic        tx_full;

  logic [7:0]  w_data_a, w_data_b;
  logic        wr_a, wr_b, busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .NUM_BYTES(3), .SYNC_BYTE(8'hA5), .INIT_DATA(24'h140846),
    .SEND_ON_CHANGE(1'b1), .RESEND_CYCLES(0)
  ) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .send_req(send_req), .tx_full(tx_full),
    .w_data(w_data_a), .wr_uart(wr_a), .busy(busy_a), .frame_done(done_a)
  );

  uart_frame_tx #(
    .NUM_BYTES(3), .SYNC_BYTE(8'hA5), .INIT_DATA(24'h140846),
    .SEND_ON_CHANGE(1'b1), .RESEND_CYCLES(16)
  ) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .send_req(send_req), .tx_full(tx_full),
    .w_data(w_data_b), .wr_uart(wr_b), .busy(busy_b), .frame_done(done_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: an in-flight frame is a queue of bytes still to be written.
  logic [7:0]  mq [2][$];
  logic        m_pend  [2];
  logic [23:0] m_last  [2];
  int unsigned m_timer [2];
  logic [7:0]  e_data  [2];
  logic        e_wr    [2];
  logic        e_busy  [2];
  logic        e_done  [2];

  // Logs of dut_a writes and dut_b frame completions for directed checks.
  logic [7:0] wlog[$];
  int         wcyc[$];
  int         done_a_cyc[$];
  int         done_b_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned resend_of(input int k);
    return (k == 0) ? 0 : 16;
  endfunction

  task automatic model_step(input int k);
    int unsigned r;
    logic        trig;
    logic [7:0]  x;
    logic [7:0]  b;
    r = resend_of(k);
    if (rst) begin
      mq[k].delete();
      m_pend[k]  = 1'b0;
      m_last[k]  = 24'h140846;
      m_timer[k] = 0;
      e_data[k]  = 8'h00;
      e_wr[k]    = 1'b0;
      e_busy[k]  = 1'b0;
      e_done[k]  = 1'b0;
      return;
    end
    e_wr[k]   = 1'b0;
    e_done[k] = 1'b0;
    if (mq[k].size() == 0) begin
      trig = send_req || m_pend[k] || (data_in != m_last[k]) ||
             ((r != 0) && (m_timer[k] == r - 1));
      if (trig) begin
        x = 8'h00;
        mq[k].push_back(8'hA5);
        for (int i = 0; i < 3; i++) begin
          b = data_in[8*i +: 8];
          mq[k].push_back(b);
          x = x ^ b;
        end
        mq[k].push_back(x);
        m_last[k]  = data_in;
        m_pend[k]  = 1'b0;
        m_timer[k] = 0;
        e_busy[k]  = 1'b1;
      end else if ((r != 0) && (m_timer[k] < r - 1)) begin
        m_timer[k] = m_timer[k] + 1;
      end
    end else begin
      if (send_req) m_pend[k] = 1'b1;
      if (!tx_full) begin
        e_data[k] = mq[k].pop_front();
        e_wr[k]   = 1'b1;
        if (mq[k].size() == 0) begin
          e_done[k] = 1'b1;
          e_busy[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    check("a_wr",   32'(wr_a),     32'(e_wr[0]));
    check("a_data", 32'(w_data_a), 32'(e_data[0]));
    check("a_busy", 32'(busy_a),   32'(e_busy[0]));
    check("a_done", 32'(done_a),   32'(e_done[0]));
    check("b_wr",   32'(wr_b),     32'(e_wr[1]));
    check("b_data", 32'(w_data_b), 32'(e_data[1]));
    check("b_busy", 32'(busy_b),   32'(e_busy[1]));
    check("b_done", 32'(done_b),   32'(e_done[1]));
    if (wr_a === 1'b1) begin
      wlog.push_back(w_data_a);
      wcyc.push_back(cyc);
    end
    if (done_a === 1'b1) done_a_cyc.push_back(cyc);
    if (done_b === 1'b1) done_b_cyc.push_back(cyc);
  endtask

  task automatic clear_logs();
    wlog.delete();
    wcyc.delete();
    done_a_cyc.delete();
    done_b_cyc.delete();
  endtask

  initial begin
    logic [7:0] exp2 [5];
    logic [7:0] exp4 [5];
    int tr;
    exp2 = '{8'hA5, 8'h46, 8'h08, 8'h14, 8'h5A};
    exp4 = '{8'hA5, 8'h46, 8'h09, 8'h14, 8'h5B};

    // Reset held 3 cycles, then idle with unchanged payload.
    rst = 1'b1; data_in = 24'h140846; send_req = 1'b0; tx_full = 1'b0;
    repeat (3) tick();
    check("rst_wr",   32'(wr_a),     32'd0);
    check("rst_data", 32'(w_data_a), 32'h00);
    check("rst_busy", 32'(busy_a),   32'd0);
    check("rst_done", 32'(done_a),   32'd0);
    rst = 1'b0;
    clear_logs();
    repeat (10) tick();
    check("idle_no_frame", 32'(wlog.size()), 32'd0);

    // Single request, no backpressure.
    clear_logs();
    tr = cyc + 1;
    send_req = 1'b1; tick(); send_req = 1'b0;
    repeat (8) tick();
    check("req_count", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      check("req_byte", 32'(wlog[i]), 32'(exp2[i]));
      check("req_cyc",  32'(wcyc[i]), 32'(tr + 1 + i));
    end
    check("req_done_cyc", (done_a_cyc.size() > 0) ? 32'(done_a_cyc[0]) : 32'hFFFF_FFFF,
          32'(tr + 5));
    check("req_busy_after", 32'(busy_a), 32'd0);

    // Backpressure for 3 cycles after byte 46.
    clear_logs();
    tr = cyc + 1;
    send_req = 1'b1; tick(); send_req = 1'b0;
    tick(); tick();
    tx_full = 1'b1; repeat (3) tick(); tx_full = 1'b0;
    repeat (8) tick();
    check("bp_count", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      check("bp_byte", 32'(wlog[i]), 32'(exp2[i]));
      check("bp_cyc",  32'(wcyc[i]), 32'((i < 2) ? tr + 1 + i : tr + 4 + i));
    end

    // Payload change in idle triggers one frame, then silence.
    clear_logs();
    tr = cyc + 1;
    data_in = 24'h140946;
    repeat (25) tick();
    check("chg_count", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      check("chg_byte", 32'(wlog[i]), 32'(exp4[i]));
      check("chg_cyc",  32'(wcyc[i]), 32'(tr + 1 + i));
    end

    // Three requests during a frame merge into exactly one follow-up frame.
    clear_logs();
    tr = cyc + 1;
    send_req = 1'b1; tick(); send_req = 1'b0;
    for (int p = 0; p < 3; p++) begin
      send_req = 1'b1; tick(); send_req = 1'b0;
      if (p < 2) tick();
    end
    repeat (20) tick();
    check("merge_count", 32'(wlog.size()), 32'd10);
    if (wlog.size() >= 10) begin
      check("merge_sync",  32'(wlog[5]), 32'hA5);
      check("merge_start", 32'(wcyc[5]), 32'(tr + 7));
      check("merge_csum",  32'(wlog[9]), 32'h5B);
    end

    // Quiet period: keep-alive spacing on dut_b, nothing from dut_a.
    clear_logs();
    repeat (80) tick();
    check("ka_a_silent", 32'(wlog.size()), 32'd0);
    check("ka_frames", 32'(done_b_cyc.size() >= 3), 32'd1);
    for (int i = 1; i < done_b_cyc.size(); i++) begin
      check("ka_period", 32'(done_b_cyc[i] - done_b_cyc[i-1]), 32'd21);
    end

    // Reset after two bytes aborts the frame for good.
    clear_logs();
    send_req = 1'b1; tick(); send_req = 1'b0;
    tick(); tick();
    check("abort_pre", 32'(wlog.size()), 32'd2);
    rst = 1'b1; data_in = 24'h140846;
    tick();
    check("abort_wr",   32'(wr_a),   32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
    repeat (10) tick();
    check("abort_no_resume", 32'(wlog.size()), 32'd2);

    // Randomized traffic against the model.
    repeat (3000) begin
      rst      = ($urandom_range(0, 499) == 0);
      send_req = ($urandom_range(0, 19) == 0);
      tx_full  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) data_in = 24'($urandom());
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
